// File: rtl/drone_top_if.sv
// Command/feedback bundle between the flight controller and its surroundings.
interface drone_top_if;
  logic signed [15:0] altcmd;
  logic        [2:0]  dircmd;
  logic signed [15:0] rpm_sense [4];
  logic signed [15:0] mot_set   [4];

  modport master (
    output altcmd,
    output dircmd,
    output rpm_sense,
    input  mot_set
  );

  modport slave (
    input  altcmd,
    input  dircmd,
    input  rpm_sense,
    output mot_set
  );
endinterface

// File: rtl/drone_top.sv
// Quad-rotor core: command -> per-motor targets (stage 1), integral loop
// driving the motor setpoints toward those targets (stage 2).
module drone_top #(
  parameter int MAX_RPM   = 10000,
  parameter int DIR_DELTA = 500,
  parameter int KP_SHIFT  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  drone_top_if.slave  bus
);

  localparam logic signed [17:0] MAXR = 18'(MAX_RPM);
  localparam logic signed [15:0] MAX16 = 16'(MAX_RPM);
  localparam logic signed [17:0] DD   = 18'(DIR_DELTA);

  logic signed [17:0] off   [4];
  logic signed [15:0] tgt_q [4];
  logic               kill_q;
  logic signed [15:0] mot_q [4];
  logic signed [17:0] err   [4];
  logic signed [17:0] upd   [4];
  logic signed [17:0] alt18;

  function automatic logic signed [15:0] clamp(input logic signed [17:0] v);
    if (v < 18'sd0)
      return '0;
    else if (v > MAXR)
      return MAX16;
    else
      return v[15:0];
  endfunction

  // Per-motor direction offsets; motors ordered FL, FR, RR, RL.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) off[i] = '0;
    case (bus.dircmd)
      3'd1: begin off[0] = -DD; off[1] = -DD; off[2] =  DD; off[3] =  DD; end
      3'd2: begin off[0] =  DD; off[1] =  DD; off[2] = -DD; off[3] = -DD; end
      3'd3: begin off[0] = -DD; off[1] =  DD; off[2] =  DD; off[3] = -DD; end
      3'd4: begin off[0] =  DD; off[1] = -DD; off[2] = -DD; off[3] =  DD; end
      3'd5: begin off[0] =  DD; off[1] = -DD; off[2] =  DD; off[3] = -DD; end
      3'd6: begin off[0] = -DD; off[1] =  DD; off[2] = -DD; off[3] =  DD; end
      default: ;
    endcase
  end

  assign alt18 = 18'(bus.altcmd);

  // Stage 1: register clamped targets and the kill flag.
  always_ff @(posedge clk) begin
    if (resetn) begin
      kill_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) tgt_q[i] <= '0;
    end else begin
      kill_q <= (bus.altcmd <= 16'sd0);
      for (int unsigned i = 0; i < 4; i++)
        tgt_q[i] <= (bus.altcmd <= 16'sd0) ? '0 : clamp(alt18 + off[i]);
    end
  end

  // Loop error and candidate setpoint; >>> floors, so small negative errors still step down.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      err[i] = 18'(tgt_q[i]) - 18'(bus.rpm_sense[i]);
      upd[i] = 18'(mot_q[i]) + (err[i] >>> KP_SHIFT);
    end
  end

  // Stage 2: setpoint integration, forced to zero while killed.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int unsigned i = 0; i < 4; i++) mot_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++)
        mot_q[i] <= kill_q ? '0 : clamp(upd[i]);
    end
  end

  assign bus.mot_set = mot_q;

endmodule

// File: tb/tb_drone_top.sv
// Randomized + directed bench for drone_top against an integer reference model.
module tb_drone_top;

  localparam int MAXR = 10000;
  localparam int DD   = 500;
  localparam int KS   = 2;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  drone_top_if bus();

  drone_top #(
    .MAX_RPM  (MAXR),
    .DIR_DELTA(DD),
    .KP_SHIFT (KS)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit ideal = 1'b1;
  int forced [4];
  int m_mot  [4];
  int m_tgt  [4];
  bit m_kill;

  // Plant stand-in: either ideal (sense follows setpoint) or forced values.
  always_comb begin
    for (int i = 0; i < 4; i++)
      bus.rpm_sense[i] = ideal ? bus.mot_set[i] : 16'(forced[i]);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > MAXR) return MAXR;
    return v;
  endfunction

  // Floor division by the loop gain divisor.
  function automatic int fdiv(input int e);
    int d;
    d = 1 << KS;
    if (e >= 0) return e / d;
    return -((-e + d - 1) / d);
  endfunction

  function automatic int offs(input int dir, input int i);
    int s [4];
    case (dir)
      1: s = '{-1, -1,  1,  1};
      2: s = '{ 1,  1, -1, -1};
      3: s = '{-1,  1,  1, -1};
      4: s = '{ 1, -1, -1,  1};
      5: s = '{ 1, -1,  1, -1};
      6: s = '{-1,  1, -1,  1};
      default: s = '{0, 0, 0, 0};
    endcase
    return s[i] * DD;
  endfunction

  // One clock: drive inputs, advance the model, check all four setpoints.
  task automatic tick(input bit rst, input int alt, input int dir);
    int nm [4];
    int sense;
    @(negedge clk);
    resetn     = rst;
    bus.altcmd = 16'(alt);
    bus.dircmd = 3'(dir);
    for (int i = 0; i < 4; i++) begin
      sense = ideal ? m_mot[i] : forced[i];
      nm[i] = m_kill ? 0 : clampi(m_mot[i] + fdiv(m_tgt[i] - sense));
    end
    if (rst) begin
      m_kill = 1'b0;
      for (int i = 0; i < 4; i++) begin m_mot[i] = 0; m_tgt[i] = 0; end
    end else begin
      m_kill = (alt <= 0);
      for (int i = 0; i < 4; i++) begin
        m_mot[i] = nm[i];
        m_tgt[i] = m_kill ? 0 : clampi(alt + offs(dir, i));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      chk($sformatf("mot%0d", i), int'(bus.mot_set[i]), m_mot[i]);
  endtask

  task automatic do_reset();
    tick(1'b1, 0, 0);
    tick(1'b1, 0, 0);
  endtask

  initial begin
    int alt, dir;
    int exp_hover [3];
    resetn     = 1'b1;
    bus.altcmd = '0;
    bus.dircmd = '0;
    for (int i = 0; i < 4; i++) forced[i] = 0;
    for (int i = 0; i < 4; i++) begin m_mot[i] = 0; m_tgt[i] = 0; end
    m_kill = 1'b0;
    exp_hover = '{1000, 1750, 2312};

    // Reset state
    ideal = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) chk("reset_zero", int'(bus.mot_set[i]), 0);

    // Ideal-plant hover: 2-edge latency, then 1000, 1750, 2312, settle 3997
    tick(1'b0, 4000, 0);
    chk("hover_latency", int'(bus.mot_set[0]), 0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 4000, 0);
      chk("hover_seq", int'(bus.mot_set[1]), exp_hover[k]);
    end
    for (int k = 0; k < 40; k++) tick(1'b0, 4000, 0);
    for (int i = 0; i < 4; i++) chk("hover_settle", int'(bus.mot_set[i]), 3997);

    // Kill from steady state: zero on the second edge
    tick(1'b0, -100, 0);
    chk("kill_edge1", int'(bus.mot_set[2]), 3997);
    tick(1'b0, -100, 0);
    for (int i = 0; i < 4; i++) chk("kill_edge2", int'(bus.mot_set[i]), 0);
    tick(1'b0, 0, 3);
    chk("kill_zero_alt", int'(bus.mot_set[0]), 0);

    // Forward from rest
    do_reset();
    for (int k = 0; k < 45; k++) tick(1'b0, 4000, 1);
    chk("fwd_m0", int'(bus.mot_set[0]), 3497);
    chk("fwd_m1", int'(bus.mot_set[1]), 3497);
    chk("fwd_m2", int'(bus.mot_set[2]), 4497);
    chk("fwd_m3", int'(bus.mot_set[3]), 4497);

    // Saturation with sense held at 0
    do_reset();
    ideal = 1'b0;
    for (int i = 0; i < 4; i++) forced[i] = 0;
    tick(1'b0, 32767, 4);
    for (int k = 1; k <= 6; k++) begin
      tick(1'b0, 32767, 4);
      for (int i = 0; i < 4; i++) chk("sat", int'(bus.mot_set[i]), (k >= 4) ? 10000 : 2500 * k);
    end

    // Overspeed: reach 4000, then sense forced to 6000, floor at 0
    do_reset();
    for (int i = 0; i < 4; i++) forced[i] = 0;
    tick(1'b0, 4000, 0);
    for (int k = 0; k < 4; k++) tick(1'b0, 4000, 0);
    chk("ovs_start", int'(bus.mot_set[3]), 4000);
    for (int i = 0; i < 4; i++) forced[i] = 6000;
    for (int k = 1; k <= 12; k++) begin
      tick(1'b0, 4000, 0);
      chk("ovs", int'(bus.mot_set[0]), (4000 - 500 * k < 0) ? 0 : 4000 - 500 * k);
    end

    // Mid-run reset during ramp
    ideal = 1'b1;
    do_reset();
    tick(1'b0, 4000, 0);
    tick(1'b0, 4000, 0);
    tick(1'b0, 4000, 0);
    chk("mid_pre", int'(bus.mot_set[0]), 1750);
    tick(1'b1, 4000, 0);
    for (int i = 0; i < 4; i++) chk("mid_rst", int'(bus.mot_set[i]), 0);
    tick(1'b0, 4000, 0);
    chk("mid_restart0", int'(bus.mot_set[0]), 0);
    tick(1'b0, 4000, 0);
    chk("mid_restart1", int'(bus.mot_set[0]), 1000);

    // Randomized phase
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        ideal = $urandom_range(0, 1) == 1;
        for (int i = 0; i < 4; i++) forced[i] = int'($urandom_range(0, 65535)) - 32768;
      end
      case ($urandom_range(0, 7))
        0: alt = int'($urandom_range(0, 65535)) - 32768;
        1: alt = int'($urandom_range(0, 600)) - 300;
        2: alt = 32767;
        default: alt = int'($urandom_range(0, 12000));
      endcase
      dir = int'($urandom_range(0, 7));
      tick($urandom_range(0, 49) == 0, alt, dir);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
